// File: rtl/seven_seg_pkg.sv
// Shared constants for the quad BCD seven-segment driver.
// All segment codes are active-low in g..a order (bit 0 = a, bit 6 = g).
package seven_seg_pkg;

  localparam int unsigned DIGIT_COUNT = 4;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/quad_bcd_seven_seg_driver_bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble to active-low seven-segment decoder.
// Ports:
//   bcd - 4-bit BCD nibble; values A-F are not valid BCD
//   seg - active-low cathodes, seg[0]=a .. seg[6]=g; invalid nibbles show a dash
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/quad_bcd_seven_seg_driver.sv
// quad_bcd_seven_seg_driver: time-multiplexed 4-digit seven-segment driver.
// Captures a snapshot of all four BCD digits once per scan (in the blank phase
// of digit 0's slot), then scans the anodes with BLANK_CYCLES of all-off guard
// at the start of every slot. All outputs are registered.
// Optional macro LEADING_ZERO_BLANK_EN: suppress leading-zero digits 3..1.
// Ports:
//   Clk    - system clock, rising edge
//   Reset  - asynchronous active-low reset
//   DataIn - four BCD digits, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   DpIn   - per-digit decimal-point request, active-high
//   Seg    - cathodes a..g, active-low
//   Dp     - decimal-point cathode, active-low
//   An     - anodes, active-low, An[n] enables digit n
module quad_bcd_seven_seg_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DpIn,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [3:0]  An
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W = $clog2(DIGIT_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             suppress;

  // Slot counter, digit pointer and once-per-scan snapshot.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    digit_d   = digit_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + DIG_W'(1);
    end
    // Start of digit 0's slot is always blank, so loading here never tears.
    if (digit_q == '0 && cnt_q == '0) begin
      snap_d    = DataIn;
      snap_dp_d = DpIn;
    end
  end

  always_comb nibble = snap_q[4*digit_q +: 4];

  bcd_to_seg u_bcd_to_seg (
    .bcd (nibble),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 is dark when it and every digit above it are zero.
  always_comb begin
    suppress = 1'b0;
    case (digit_q)
      2'd1:    suppress = (snap_q[15:4]  == '0);
      2'd2:    suppress = (snap_q[15:8]  == '0);
      2'd3:    suppress = (snap_q[15:12] == '0);
      default: suppress = 1'b0;
    endcase
  end
`else
  always_comb suppress = 1'b0;
`endif

  // Next registered outputs: blank guard first, then the selected digit.
  always_comb begin
    an_d  = ANODES_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (cnt_q >= BLANK_END && !suppress) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = dec_seg;
      dp_d  = ~snap_dp_q[digit_q];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q     <= '0;
      digit_q   <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      an_q      <= ANODES_OFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_quad_bcd_seven_seg_driver.sv
// Testbench for quad_bcd_seven_seg_driver (REFRESH_DIV=4, BLANK_CYCLES=1).
// Expected lit-digit cycles are queued as stimulus is issued; a monitor pops
// one entry every cycle the DUT drives a lit anode pattern.
module tb_quad_bcd_seven_seg_driver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] DataIn = 16'h1234;
  logic [3:0]  DpIn = 4'b0010;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  An;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic [11:0] exp_q [$];   // {An, Seg, Dp}

  quad_bcd_seven_seg_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .DataIn (DataIn),
    .DpIn   (DpIn),
    .Seg    (Seg),
    .Dp     (Dp),
    .An     (An)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got An/Seg/Dp=%b_%b_%b, want %b_%b_%b t=%0t",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0], $time);
    end
  endtask

  // One slot lights its digit for 3 cycles (4-cycle slot, 1 blank).
  task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                           input int n = 3);
    for (int i = 0; i < n; i++) exp_q.push_back({an, seg, dp});
  endtask

  task automatic push_1234_scan();
    push_slot(4'b1110, 7'b0011001, 1'b1);
    push_slot(4'b1101, 7'b0110000, 1'b0);
    push_slot(4'b1011, 7'b0100100, 1'b1);
    push_slot(4'b0111, 7'b1111001, 1'b1);
  endtask

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (mon_en && An !== 4'b1111) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_lit", {An, Seg, Dp}, {4'b1111, 7'b1111111, 1'b1});
      end else begin
        chk("lit_digit", {An, Seg, Dp}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset held for 3 cycles: outputs blank, no X.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("reset_blank", {An, Seg, Dp}, {4'b1111, 7'b1111111, 1'b1});
    end
    push_1234_scan();
    Reset  = 1'b1;
    mon_en = 1'b1;
    cyc    = 0;

    // Each scan's data is changed mid-slot 2 and shows from the next scan.
    for (int s = 0; s < 5; s++) begin
      while (cyc < 16*s + 10) begin @(negedge Clk); cyc++; end
      case (s)
        0: begin
          DataIn = 16'h9999; DpIn = 4'b0000;
          push_slot(4'b1110, 7'b0010000, 1'b1);
          push_slot(4'b1101, 7'b0010000, 1'b1);
          push_slot(4'b1011, 7'b0010000, 1'b1);
          push_slot(4'b0111, 7'b0010000, 1'b1);
        end
        1: begin
          DataIn = 16'h00A5; DpIn = 4'b0000;
          push_slot(4'b1110, 7'b0010010, 1'b1);
          push_slot(4'b1101, 7'b0111111, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
          push_slot(4'b1011, 7'b1000000, 1'b1);
          push_slot(4'b0111, 7'b1000000, 1'b1);
`endif
        end
        2: begin
          DataIn = 16'h0007; DpIn = 4'b0100;
          push_slot(4'b1110, 7'b1111000, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
          push_slot(4'b1101, 7'b1000000, 1'b1);
          push_slot(4'b1011, 7'b1000000, 1'b0);
          push_slot(4'b0111, 7'b1000000, 1'b1);
`endif
        end
        3: begin
          DataIn = 16'h0000; DpIn = 4'b0000;
          push_slot(4'b1110, 7'b1000000, 1'b1);
`ifndef LEADING_ZERO_BLANK_EN
          push_slot(4'b1101, 7'b1000000, 1'b1);
          push_slot(4'b1011, 7'b1000000, 1'b1);
          push_slot(4'b0111, 7'b1000000, 1'b1);
`endif
        end
        default: begin
          DataIn = 16'h1234; DpIn = 4'b0010;
          // Scan is cut by reset after the first lit cycle of digit 2.
          push_slot(4'b1110, 7'b0011001, 1'b1);
          push_slot(4'b1101, 7'b0110000, 1'b0);
          push_slot(4'b1011, 7'b0100100, 1'b1, 1);
        end
      endcase
    end

    // Cycle 90: first lit cycle of digit 2; pulse reset for half a cycle.
    while (cyc < 90) begin @(negedge Clk); cyc++; end
    #1 Reset = 1'b0;
    #1 chk("async_reset_blank", {An, Seg, Dp}, {4'b1111, 7'b1111111, 1'b1});
    push_1234_scan();
    #4 Reset = 1'b1;
    cyc = 0;
    while (cyc < 2) begin @(negedge Clk); cyc++; end
    chk("post_reset_first_edge_blank", {An, Seg, Dp}, {4'b1111, 7'b1111111, 1'b1});
    @(negedge Clk); cyc++;
    chk("post_reset_digit0_lit", {An, Seg, Dp}, {4'b1110, 7'b0011001, 1'b1});
    while (cyc < 18) begin @(negedge Clk); cyc++; end
    mon_en = 1'b0;
    chk("scoreboard_drained", {An, 7'(exp_q.size()), 1'b1}, {4'b1111, 7'd0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
